// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: registered sources, per-source level/edge
// mode, enable mask, fixed priority (bit 0 highest) and an atomic claim register.
module irq_controller #(
   parameter int NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               resetq,
   input  logic               select,
   input  logic [2:0]         addr,
   input  logic [3:0]         we,
   input  logic               rd,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic               irq_out
);

   localparam logic [2:0] A_RAW     = 3'd0;
   localparam logic [2:0] A_PENDING = 3'd1;
   localparam logic [2:0] A_ENABLE  = 3'd2;
   localparam logic [2:0] A_EDGE    = 3'd3;
   localparam logic [2:0] A_SET     = 3'd4;
   localparam logic [2:0] A_CLAIM   = 3'd5;

   // Internal state is held 32 bits wide; bits at or above NUM_SRC are forced
   // to zero so they read 0 and ignore writes.
   localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                    : 32'((64'd1 << NUM_SRC) - 64'd1);

   logic [31:0] r_raw;
   logic [31:0] r_epend;
   logic [31:0] r_enable;
   logic [31:0] r_edge;
   logic [31:0] r_rdata;
   logic        r_irq;

   logic [31:0] w_in;
   logic [31:0] w_lanes;
   logic [31:0] w_wmask;
   logic [31:0] w_rise;
   logic [31:0] w_pend;
   logic [31:0] w_act;
   logic [31:0] w_onehot;
   logic [4:0]  w_idx;
   logic        w_valid;
   logic        w_wr;
   logic        w_rd;
   logic        w_claim;
   logic [31:0] w_enable_nx;
   logic [31:0] w_edge_nx;
   logic [31:0] w_set;
   logic [31:0] w_clr;
   logic [31:0] w_epend_nx;
   logic [31:0] w_rd_mux;

   always_comb begin
      w_in = '0;
      w_in[NUM_SRC-1:0] = irq_in;
   end

   assign w_wr    = select & (we != 4'b0000);
   assign w_rd    = select & rd;
   assign w_lanes = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
   assign w_wmask = w_lanes & SRC_MASK;

   assign w_rise  = w_in & ~r_raw;
   assign w_pend  = (r_edge & r_epend) | (~r_edge & r_raw);
   assign w_act   = w_pend & r_enable;
   assign w_valid = |w_act;

   // Scan from the top so the last hit, the lowest index, wins.
   always_comb begin
      w_onehot = '0;
      w_idx    = '0;
      for (int i = 31; i >= 0; i--) begin
         if (w_act[i]) begin
            w_onehot    = '0;
            w_onehot[i] = 1'b1;
            w_idx       = 5'(i);
         end
      end
   end

   assign w_enable_nx = (w_wr && addr == A_ENABLE)
                      ? ((r_enable & ~w_wmask) | (wdata & w_wmask)) : r_enable;
   assign w_edge_nx   = (w_wr && addr == A_EDGE)
                      ? ((r_edge & ~w_wmask) | (wdata & w_wmask)) : r_edge;

   assign w_claim = w_rd && (addr == A_CLAIM) && w_valid;

   // Clear sources: W1C, mode change, edge-mode claim. Set sources override them.
   assign w_set = w_rise
                | ((w_wr && addr == A_SET) ? (wdata & w_wmask & r_edge) : 32'h0);
   assign w_clr = ((w_wr && addr == A_PENDING) ? (wdata & w_wmask & r_edge) : 32'h0)
                | (r_edge ^ w_edge_nx)
                | (w_claim ? (w_onehot & r_edge) : 32'h0);
   assign w_epend_nx = ((r_epend & ~w_clr) | w_set) & SRC_MASK;

   always_comb begin
      w_rd_mux = '0;
      case (addr)
         A_RAW:     w_rd_mux = r_raw;
         A_PENDING: w_rd_mux = w_pend;
         A_ENABLE:  w_rd_mux = r_enable;
         A_EDGE:    w_rd_mux = r_edge;
         A_CLAIM:   w_rd_mux = {w_valid, 26'b0, w_idx};
         default:   w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         r_raw    <= '0;
         r_epend  <= '0;
         r_enable <= '0;
         r_edge   <= '0;
         r_rdata  <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_raw    <= w_in;
         r_epend  <= w_epend_nx;
         r_enable <= w_enable_nx;
         r_edge   <= w_edge_nx;
         r_irq    <= w_valid;
         if (w_rd) begin
            r_rdata <= w_rd_mux;
         end
      end
   end

   assign rdata   = r_rdata;
   assign irq_out = r_irq;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random bus/source traffic,
// checked by a behavioural model feeding a scoreboard queue.
module tb_irq_controller;

   localparam int N = 8;

   logic          clk    = 1'b0;
   logic          resetq = 1'b0;
   logic          select = 1'b0;
   logic [2:0]    addr   = '0;
   logic [3:0]    we     = '0;
   logic          rd     = 1'b0;
   logic [31:0]   wdata  = '0;
   logic [31:0]   rdata;
   logic [N-1:0]  irq_in = '0;
   logic          irq_out;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   irq_controller #(.NUM_SRC(N)) dut (
      .clk     (clk),
      .resetq  (resetq),
      .select  (select),
      .addr    (addr),
      .we      (we),
      .rd      (rd),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq_in  (irq_in),
      .irq_out (irq_out)
   );

   always #5 clk = ~clk;

   // Reference model state, one bit per source.
   logic [7:0] m_raw   = '0;
   logic [7:0] m_epend = '0;
   logic [7:0] m_en    = '0;
   logic [7:0] m_edge  = '0;
   logic       m_irq   = 1'b0;
   logic       m_rd_pend = 1'b0;
   logic       mon_on  = 1'b0;

   function automatic int lowest_set(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin : model
      logic [7:0]  pend;
      logic [7:0]  act;
      logic [7:0]  set_v;
      logic [7:0]  clr_v;
      logic [7:0]  en_nx;
      logic [7:0]  edge_nx;
      logic [31:0] rv;
      logic        wr;
      int          win;
      mon_on = 1'b1;
      if (!resetq) begin
         m_raw = '0; m_epend = '0; m_en = '0; m_edge = '0;
         m_irq = 1'b0; m_rd_pend = 1'b0;
      end else begin
         pend = (m_edge & m_epend) | (~m_edge & m_raw);
         act  = pend & m_en;
         win  = lowest_set(act);
         wr   = select && (we != 4'b0000);
         case (addr)
            3'd0:    rv = {24'h0, m_raw};
            3'd1:    rv = {24'h0, pend};
            3'd2:    rv = {24'h0, m_en};
            3'd3:    rv = {24'h0, m_edge};
            3'd5:    rv = (win >= 0) ? {1'b1, 26'b0, 5'(win)} : 32'h0;
            default: rv = 32'h0;
         endcase
         if (select && rd) begin
            exp_q.push_back(rv);
            m_rd_pend = 1'b1;
         end else begin
            m_rd_pend = 1'b0;
         end
         // With 8 sources only byte lane 0 can change anything.
         en_nx   = (wr && addr == 3'd2 && we[0]) ? wdata[7:0] : m_en;
         edge_nx = (wr && addr == 3'd3 && we[0]) ? wdata[7:0] : m_edge;
         set_v = irq_in & ~m_raw;
         if (wr && addr == 3'd4 && we[0]) set_v = set_v | (wdata[7:0] & m_edge);
         clr_v = m_edge ^ edge_nx;
         if (wr && addr == 3'd1 && we[0]) clr_v = clr_v | (wdata[7:0] & m_edge);
         if (select && rd && addr == 3'd5 && win >= 0 && m_edge[win]) clr_v[win] = 1'b1;
         m_epend = (m_epend & ~clr_v) | set_v;
         m_irq   = (act != 8'h0);
         m_raw   = irq_in;
         m_en    = en_nx;
         m_edge  = edge_nx;
      end
   end

   // Monitor: irq_out every cycle, rdata whenever a read result is due.
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      if (mon_on) begin
         checks++;
         if (irq_out !== m_irq) begin
            failures++;
            $display("FAIL irq_out @%0t: got %0b expected %0b", $time, irq_out, m_irq);
         end
         if (m_rd_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rdata @%0t: no expected value queued, got %h", $time, rdata);
            end else begin
               e = exp_q.pop_front();
               if (rdata !== e) begin
                  failures++;
                  $display("FAIL rdata @%0t: got %h expected %h", $time, rdata, e);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [7:0] iv, output logic [31:0] d);
      @(negedge clk);
      irq_in = iv; select = 1'b1; rd = 1'b1; we = 4'h0; addr = a;
      @(negedge clk);
      select = 1'b0; rd = 1'b0;
      d = rdata;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] wd,
                            input logic [3:0] w, input logic [7:0] iv);
      @(negedge clk);
      irq_in = iv; select = 1'b1; rd = 1'b0; we = w; addr = a; wdata = wd;
      @(negedge clk);
      select = 1'b0; we = 4'h0;
   endtask

   task automatic idle(input int n, input logic [7:0] iv);
      repeat (n) begin
         @(negedge clk);
         irq_in = iv;
      end
   endtask

   initial begin : driver
      logic [31:0] d;
      // Reset with all sources high.
      resetq = 1'b0;
      irq_in = 8'hFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rdata", rdata, 32'h0);
      check("reset_irq", {31'h0, irq_out}, 32'h0);
      resetq = 1'b1;
      bus_read(3'd1, 8'hFF, d);
      check("reset_pending_level", d, 32'h0000_00FF);
      check("reset_irq_masked", {31'h0, irq_out}, 32'h0);

      // Edge latch and claim.
      bus_write(3'd3, 32'h06, 4'hF, 8'h00);
      bus_write(3'd2, 32'h06, 4'hF, 8'h00);
      idle(1, 8'h04);
      idle(2, 8'h00);
      check("edge_irq_assert", {31'h0, irq_out}, 32'h1);
      bus_read(3'd5, 8'h00, d);
      check("claim_edge2", d, 32'h8000_0002);
      idle(1, 8'h00);
      check("claim_irq_drop", {31'h0, irq_out}, 32'h0);
      bus_read(3'd5, 8'h00, d);
      check("claim_empty", d, 32'h0);

      // Priority between two edge sources.
      idle(1, 8'h06);
      idle(1, 8'h00);
      bus_read(3'd5, 8'h00, d);
      check("prio_first", d, 32'h8000_0001);
      bus_read(3'd5, 8'h00, d);
      check("prio_second", d, 32'h8000_0002);
      bus_read(3'd5, 8'h00, d);
      check("prio_empty", d, 32'h0);

      // Set-wins collisions on bit 1.
      idle(1, 8'h02);
      idle(1, 8'h00);
      bus_write(3'd1, 32'h02, 4'hF, 8'h02);
      bus_read(3'd1, 8'h00, d);
      check("w1c_collision", {31'h0, d[1]}, 32'h1);
      bus_read(3'd5, 8'h02, d);
      check("claim_collision_word", d, 32'h8000_0001);
      bus_read(3'd1, 8'h00, d);
      check("claim_collision", {31'h0, d[1]}, 32'h1);
      bus_read(3'd5, 8'h00, d);
      check("claim_drain", d, 32'h8000_0001);

      // Level source 0.
      bus_write(3'd2, 32'h01, 4'hF, 8'h01);
      bus_read(3'd5, 8'h01, d);
      check("level_claim1", d, 32'h8000_0000);
      bus_read(3'd5, 8'h01, d);
      check("level_claim2", d, 32'h8000_0000);
      check("level_irq_held", {31'h0, irq_out}, 32'h1);
      idle(1, 8'h00);
      idle(1, 8'h00);
      check("level_drop_e0", {31'h0, irq_out}, 32'h1);
      idle(1, 8'h00);
      check("level_drop_e1", {31'h0, irq_out}, 32'h0);

      // SET, mode change and byte lanes.
      bus_write(3'd3, 32'h80, 4'hF, 8'h00);
      bus_write(3'd4, 32'h80, 4'hF, 8'h00);
      bus_read(3'd1, 8'h00, d);
      check("set_bit7", {31'h0, d[7]}, 32'h1);
      bus_write(3'd3, 32'h00, 4'hF, 8'h00);
      bus_read(3'd1, 8'h00, d);
      check("mode_clear_bit7", {31'h0, d[7]}, 32'h0);
      idle(1, 8'h80);
      bus_read(3'd1, 8'h80, d);
      check("level_follows_raw7", {31'h0, d[7]}, 32'h1);
      bus_write(3'd3, 32'h80, 4'hF, 8'h80);
      bus_read(3'd1, 8'h80, d);
      check("mode_change_no_epend", {31'h0, d[7]}, 32'h0);
      bus_write(3'd2, 32'h0, 4'hF, 8'h00);
      bus_write(3'd2, 32'hFFFF_FFFF, 4'b0010, 8'h00);
      bus_read(3'd2, 8'h00, d);
      check("enable_lane1", d, 32'h0);
      bus_write(3'd2, 32'hFFFF_FFFF, 4'b0001, 8'h00);
      bus_read(3'd2, 8'h00, d);
      check("enable_lane0", d, 32'h0000_00FF);
      bus_read(3'd6, 8'h00, d);
      check("reg6_zero", d, 32'h0);
      bus_read(3'd4, 8'h00, d);
      check("set_reads_zero", d, 32'h0);

      // Random traffic, including occasional mid-run resets.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
         resetq = ($urandom_range(0, 149) != 0);
         select = ($urandom_range(0, 2) != 0);
         addr   = 3'($urandom_range(0, 7));
         rd     = 1'($urandom_range(0, 1));
         we     = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         wdata  = $urandom;
      end
      @(negedge clk);
      select = 1'b0; rd = 1'b0; we = 4'h0; resetq = 1'b1;
      idle(3, 8'h00);
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
